// File: rtl/dc_multichan_capture.sv
// Multichannel capture: samples CH_NUM synchronised inputs every D clocks into a FIFO and
// uploads each sample word LSB byte first. Define DC_TRIGGER_EN for the armed-trigger start.
module dc_multichan_capture #(
  parameter int CH_NUM     = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] dc_signal_in,
  input  logic              cmd_start,
  input  logic [7:0]        cmd_type,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_data_valid,
  input  logic              cmd_done,
  output logic              upload_req,
  output logic [7:0]        upload_data,
  output logic              upload_valid,
  input  logic              upload_ready,
  output logic              capture_active,
  output logic              overflow
);
  localparam int NB    = CH_NUM / 8;
`ifdef DC_TRIGGER_EN
  localparam int PL_N  = 2 * NB;
`else
  localparam int PL_N  = 2;
`endif
  localparam int IDX_W = $clog2(PL_N + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [7:0] CMD_START = 8'h0B;
  localparam logic [7:0] CMD_STOP  = 8'h0C;
`ifdef DC_TRIGGER_EN
  localparam logic [7:0] CMD_TRIG  = 8'h0D;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN
`ifdef DC_TRIGGER_EN
    , S_ARMED
`endif
  } cap_state_t;

  typedef enum logic [1:0] {U_IDLE, U_LOAD, U_SEND} up_state_t;

  logic [CH_NUM-1:0] sync1_reg, sync_in_reg;
  logic [7:0]        cmd_type_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [8*PL_N-1:0] payload_reg;
  logic [DIV_W-1:0]  div_reg, cnt_reg, div_pay;
  cap_state_t        cap_state_reg;
  up_state_t         up_state_reg;
  logic [CH_NUM-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic [CH_NUM-1:0] word_reg;
  logic [BW-1:0]     byte_idx_reg;
  logic              upload_valid_reg, overflow_reg;
  logic              apply_start, apply_stop, sampling, tick, wr_req;
  logic              fifo_empty, fifo_full, pop, push, drop, last_byte;

  // Payload byte 0 is the divider high byte
  assign div_pay     = DIV_W'({payload_reg[7:0], payload_reg[15:8]});
  assign apply_start = cmd_done && (cmd_type_reg == CMD_START);
  assign apply_stop  = cmd_done && (cmd_type_reg == CMD_STOP);

`ifdef DC_TRIGGER_EN
  logic [CH_NUM-1:0] mask_reg, value_reg;
  logic              apply_trig, trig_hit;
  assign apply_trig = cmd_done && (cmd_type_reg == CMD_TRIG);
  assign sampling   = (cap_state_reg == S_RUN) || (cap_state_reg == S_ARMED);
  assign trig_hit   = ((sync_in_reg ^ value_reg) & mask_reg) == '0;
  assign wr_req     = tick && ((cap_state_reg == S_RUN) || trig_hit);
`else
  assign sampling   = cap_state_reg == S_RUN;
  assign wr_req     = tick;
`endif

  // A START/STOP being applied this cycle cancels any coincident tick
  assign tick       = sampling && (cnt_reg == div_reg - DIV_W'(1)) && !(apply_start || apply_stop);
  assign fifo_empty = count_reg == '0;
  assign fifo_full  = count_reg == (AW+1)'(FIFO_DEPTH);
  assign pop        = up_state_reg == U_LOAD;
  assign push       = wr_req && (!fifo_full || pop);
  assign drop       = wr_req && fifo_full && !pop;
  assign last_byte  = byte_idx_reg == BW'(NB - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= '0;
      sync_in_reg   <= '0;
      cmd_type_reg  <= '0;
      idx_reg       <= '0;
      payload_reg   <= '0;
      div_reg       <= DIV_W'(1);
      cnt_reg       <= '0;
      cap_state_reg <= S_IDLE;
      overflow_reg  <= 1'b0;
`ifdef DC_TRIGGER_EN
      mask_reg      <= '0;
      value_reg     <= '0;
`endif
    end else begin
      sync1_reg   <= dc_signal_in;
      sync_in_reg <= sync1_reg;

      if (cmd_start) begin
        cmd_type_reg <= cmd_type;
        idx_reg      <= '0;
        payload_reg  <= '0;
      end else if (cmd_data_valid && idx_reg != IDX_W'(PL_N)) begin
        for (int i = 0; i < PL_N; i++)
          if (idx_reg == IDX_W'(i)) payload_reg[8*i +: 8] <= cmd_data;
        idx_reg <= idx_reg + IDX_W'(1);
      end

      if (apply_start)   cnt_reg <= '0;
      else if (sampling) cnt_reg <= tick ? '0 : cnt_reg + DIV_W'(1);

      if (apply_start) begin
        div_reg <= (div_pay == '0) ? DIV_W'(1) : div_pay;
        if (cap_state_reg == S_IDLE) begin
          overflow_reg  <= 1'b0;
`ifdef DC_TRIGGER_EN
          cap_state_reg <= (mask_reg != '0) ? S_ARMED : S_RUN;
`else
          cap_state_reg <= S_RUN;
`endif
        end
      end else if (apply_stop) begin
        cap_state_reg <= S_IDLE;
`ifdef DC_TRIGGER_EN
      end else if (cap_state_reg == S_ARMED && tick && trig_hit) begin
        cap_state_reg <= S_RUN;
`endif
      end

      if (drop) overflow_reg <= 1'b1;

`ifdef DC_TRIGGER_EN
      if (apply_trig) begin
        mask_reg  <= payload_reg[CH_NUM-1:0];
        value_reg <= payload_reg[2*CH_NUM-1:CH_NUM];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= sync_in_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      up_state_reg     <= U_IDLE;
      word_reg         <= '0;
      byte_idx_reg     <= '0;
      upload_valid_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase

      case (up_state_reg)
        U_IDLE: if (!fifo_empty) up_state_reg <= U_LOAD;
        U_LOAD: begin
          word_reg         <= mem[rd_ptr_reg];
          byte_idx_reg     <= '0;
          upload_valid_reg <= 1'b1;
          up_state_reg     <= U_SEND;
        end
        U_SEND: if (upload_ready) begin
          if (last_byte) begin
            upload_valid_reg <= 1'b0;
            up_state_reg     <= fifo_empty ? U_IDLE : U_LOAD;
          end else begin
            byte_idx_reg <= byte_idx_reg + BW'(1);
            word_reg     <= word_reg >> 8;
          end
        end
        default: up_state_reg <= U_IDLE;
      endcase
    end
  end

  assign upload_valid   = upload_valid_reg;
  assign upload_data    = word_reg[7:0];
  assign upload_req     = !fifo_empty || (up_state_reg != U_IDLE);
  assign capture_active = sampling;
  assign overflow       = overflow_reg;

endmodule
